pin_entry: RTL and testbench

Keypad-side PIN assembler that feeds the gate controller's 16-bit `pass` input. It collects four BCD digits from a strobed keypad interface and supports backspace, clear and enter. On a complete entry it presents the packed PIN to the gate controller with a valid/ready handshake. Abandoned entries are dropped after an inactivity timeout.

---
 rtl/pin_entry.sv | 162 ++++++++++++++++
 tb/tb_pin_entry.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pin_entry.sv
// pin_entry: keypad-side PIN assembler.
//   Collects four BCD digits from a strobed keypad, supports backspace,
//   clear and enter, and presents the packed PIN (first digit in [15:12])
//   to the gate controller over a valid/ready handshake. An entry left
//   idle for TIMEOUT_CYCLES cycles is dropped.
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous reset, active low
//   key        key code: 0-9 digit, B backspace, C clear, E enter
//   key_vld    one-cycle key strobe
//   pass_rdy   consumer accepts pass
//   pass       packed PIN, non-zero only while pass_vld is high
//   pass_vld   pass valid, held stable until accepted
//   digit_cnt  digits currently buffered (0..4)
//   entry_err  one-cycle pulse: enter with fewer than 4 digits
//   timeout    one-cycle pulse: entry abandoned for inactivity
module pin_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        key_vld,
  input  logic        pass_rdy,
  output logic [15:0] pass,
  output logic        pass_vld,
  output logic [2:0]  digit_cnt,
  output logic        entry_err,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  // Expiry is detected one count early so the pulse lands exactly
  // TIMEOUT_CYCLES cycles after the last key edge.
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pass_q, pass_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic [15:0] tmr_q, tmr_d;

  logic is_dig, is_bs, is_clr, is_ent, is_key;

  assign is_dig = key_vld && (key <= 4'h9);
  assign is_bs  = key_vld && (key == 4'hB);
  assign is_clr = key_vld && (key == 4'hC);
  assign is_ent = key_vld && (key == 4'hE);
  // Unrecognised codes are not key events: they neither act nor reload the timer.
  assign is_key = is_dig || is_bs || is_clr || is_ent;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    to_d    = 1'b0;
    tmr_d   = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (is_dig) begin
          buf_d   = {12'h000, key};
          cnt_d   = 3'd1;
          state_d = S_ENTRY;
        end else if (is_ent) begin
          err_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (is_key) begin
          // Any recognised key, even an ignored fifth digit, counts as activity.
          if (is_dig) begin
            if (cnt_q < 3'd4) begin
              buf_d = {buf_q[11:0], key};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (is_bs) begin
            buf_d = {4'h0, buf_q[15:4]};
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_IDLE;
          end else if (is_clr) begin
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            if (cnt_q == 3'd4) begin
              pass_d  = buf_q;
              vld_d   = 1'b1;
              state_d = S_PRESENT;
            end else begin
              err_d   = 1'b1;
              buf_d   = 16'h0000;
              cnt_d   = 3'd0;
              state_d = S_IDLE;
            end
          end
        end else if (tmr_q == TMR_LAST) begin
          to_d    = 1'b1;
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_PRESENT: begin
        // Keys are dropped here; only the handshake moves us on.
        if (pass_rdy) begin
          pass_d  = 16'h0000;
          vld_d   = 1'b0;
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        buf_d   = 16'h0000;
        cnt_d   = 3'd0;
        pass_d  = 16'h0000;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      buf_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      pass_q  <= 16'h0000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      tmr_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      to_q    <= to_d;
      tmr_q   <= tmr_d;
    end
  end

  assign pass      = pass_q;
  assign pass_vld  = vld_q;
  assign digit_cnt = cnt_q;
  assign entry_err = err_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry (TIMEOUT_CYCLES=10). Inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_pin_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        key_vld;
  logic        pass_rdy;
  logic [15:0] pass;
  logic        pass_vld;
  logic [2:0]  digit_cnt;
  logic        entry_err;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;

  pin_entry #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .key(key), .key_vld(key_vld), .pass_rdy(pass_rdy),
    .pass(pass), .pass_vld(pass_vld), .digit_cnt(digit_cnt),
    .entry_err(entry_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; key is sampled on the next rising edge and
  // the task returns on the falling edge after it.
  task automatic press(input logic [3:0] k);
    key = k;
    key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    key = 4'h0;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, ".pass"}, pass, 16'h0000);
    chk({tag, ".vld"}, {15'd0, pass_vld}, 16'd0);
    chk({tag, ".cnt"}, {13'd0, digit_cnt}, 16'd0);
    chk({tag, ".err"}, {15'd0, entry_err}, 16'd0);
    chk({tag, ".to"}, {15'd0, timeout}, 16'd0);
  endtask

  initial begin
    rst = 1'b0; key = 4'h0; key_vld = 1'b0; pass_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    idle_outs("reset");
    rst = 1'b1;

    // 4,0,3,7 enter; rdy low 5 cycles -> vld high 6 cycles
    press(4'h4); chk("t1.cnt1", {13'd0, digit_cnt}, 16'd1);
    press(4'h0); press(4'h3); press(4'h7);
    chk("t1.cnt4", {13'd0, digit_cnt}, 16'd4);
    chk("t1.hidden", pass, 16'h0000);
    press(4'hE);
    chk("t1.vld0", {15'd0, pass_vld}, 16'd1);
    chk("t1.pass0", pass, 16'h4037);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("t1.vld%0d", i), {15'd0, pass_vld}, 16'd1);
      chk($sformatf("t1.pass%0d", i), pass, 16'h4037);
    end
    pass_rdy = 1'b1;
    @(negedge clk);
    pass_rdy = 1'b0;
    chk("t1.done.vld", {15'd0, pass_vld}, 16'd0);
    chk("t1.done.pass", pass, 16'h0000);
    chk("t1.done.cnt", {13'd0, digit_cnt}, 16'd0);

    // 1,2,9,BS,5,6 then extra 8, enter; keys during PRESENT dropped
    press(4'h1); press(4'h2); press(4'h9);
    chk("t2.cnt3", {13'd0, digit_cnt}, 16'd3);
    press(4'hB);
    chk("t2.bs", {13'd0, digit_cnt}, 16'd2);
    press(4'h5); press(4'h6); press(4'h8);
    chk("t2.fifth", {13'd0, digit_cnt}, 16'd4);
    press(4'hE);
    chk("t2.pass", pass, 16'h1256);
    chk("t2.vld", {15'd0, pass_vld}, 16'd1);
    press(4'h9); press(4'hC);
    chk("t5.pres.pass", pass, 16'h1256);
    chk("t5.pres.vld", {15'd0, pass_vld}, 16'd1);
    chk("t5.pres.cnt", {13'd0, digit_cnt}, 16'd4);
    pass_rdy = 1'b1;
    @(negedge clk);
    pass_rdy = 1'b0;
    chk("t5.hs.vld", {15'd0, pass_vld}, 16'd0);
    @(negedge clk);
    idle_outs("t5.after");

    // rdy already high when vld rises -> vld high exactly one cycle
    pass_rdy = 1'b1;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
    chk("t2b.vld", {15'd0, pass_vld}, 16'd1);
    chk("t2b.pass", pass, 16'h1234);
    @(negedge clk);
    pass_rdy = 1'b0;
    chk("t2b.vld.fall", {15'd0, pass_vld}, 16'd0);
    chk("t2b.pass.fall", pass, 16'h0000);

    // short entry then enter; enter in IDLE
    press(4'h7); press(4'h7); press(4'hE);
    chk("t3.err", {15'd0, entry_err}, 16'd1);
    chk("t3.cnt", {13'd0, digit_cnt}, 16'd0);
    chk("t3.vld", {15'd0, pass_vld}, 16'd0);
    @(negedge clk);
    chk("t3.err.fall", {15'd0, entry_err}, 16'd0);
    press(4'hE);
    chk("t3.idle.err", {15'd0, entry_err}, 16'd1);
    @(negedge clk);
    chk("t3.idle.err.fall", {15'd0, entry_err}, 16'd0);

    // clear mid-entry, then enter -> entry_err
    press(4'h1); press(4'h2); press(4'hC);
    chk("t5.clr.cnt", {13'd0, digit_cnt}, 16'd0);
    press(4'hE);
    chk("t5.clr.err", {15'd0, entry_err}, 16'd1);
    @(negedge clk);

    // timeout after 10 idle cycles
    press(4'h3);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("t4.wait%0d", i), {15'd0, timeout}, 16'd0);
    end
    @(negedge clk);
    chk("t4.to", {15'd0, timeout}, 16'd1);
    chk("t4.to.cnt", {13'd0, digit_cnt}, 16'd0);
    chk("t4.to.err", {15'd0, entry_err}, 16'd0);
    @(negedge clk);
    chk("t4.to.fall", {15'd0, timeout}, 16'd0);

    // key on the expiry edge wins; timer restarts from that key
    press(4'h3);
    for (int i = 1; i <= 9; i++) @(negedge clk);
    press(4'h5);
    chk("t4.race.to", {15'd0, timeout}, 16'd0);
    chk("t4.race.cnt", {13'd0, digit_cnt}, 16'd2);
    for (int i = 1; i <= 9; i++) @(negedge clk);
    chk("t4.race.wait", {15'd0, timeout}, 16'd0);
    @(negedge clk);
    chk("t4.race.to2", {15'd0, timeout}, 16'd1);
    @(negedge clk);

    // async reset mid-entry
    press(4'h1); press(4'h2);
    chk("t6.cnt2", {13'd0, digit_cnt}, 16'd2);
    rst = 1'b0;
    #1;
    idle_outs("t6.rst1");
    @(negedge clk);
    rst = 1'b1;
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hE);
    chk("t6.pass1", pass, 16'h5678);
    chk("t6.vld1", {15'd0, pass_vld}, 16'd1);
    // async reset during PRESENT
    rst = 1'b0;
    #1;
    idle_outs("t6.rst2");
    @(negedge clk);
    rst = 1'b1;
    press(4'h9); press(4'h0); press(4'h1); press(4'h2); press(4'hE);
    chk("t6.pass2", pass, 16'h9012);
    chk("t6.vld2", {15'd0, pass_vld}, 16'd1);
    pass_rdy = 1'b1;
    @(negedge clk);
    pass_rdy = 1'b0;
    idle_outs("t6.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
